// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: FSM state
// encoding, the blank pattern and the hex-to-segment table (gfedcba, active-low).
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } seg7_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Entry n is the active-low segment pattern for hex digit n, bit 6 = g.
   localparam logic [6:0] SEG_HEX [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

endpackage

// File: rtl/seg7_scan_if.sv
// Bundle between the datapath (master) and the display scanner (slave).
interface seg7_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      TICK;
   logic [4*NUM_DIGITS-1:0]   VALUE;
   logic [NUM_DIGITS-1:0]     DP_IN;
   logic                      LZ_SUPPRESS;
   logic [NUM_DIGITS-1:0]     AN;
   logic [6:0]                SEG;
   logic                      DP;
   logic                      FRAME_DONE;

   modport master (
      output TICK, VALUE, DP_IN, LZ_SUPPRESS,
      input  AN, SEG, DP, FRAME_DONE
   );

   modport slave (
      input  TICK, VALUE, DP_IN, LZ_SUPPRESS,
      output AN, SEG, DP, FRAME_DONE
   );
endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder with a forced-blank input
// (used for leading-zero suppression).
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   // Look up the hex pattern unless the digit is being suppressed.
   always_comb begin
      seg_o = SEG_BLANK;
      if (blank_i) begin
         seg_o = SEG_BLANK;
      end else begin
         seg_o = SEG_HEX[nib_i];
      end
   end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment driver. Each digit slot is one
// blank tick followed by DIGIT_TICKS drive ticks; the displayed value is
// snapshotted once per frame so the digits of one frame are coherent.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int DIGIT_TICKS = 3
) (
   input  logic        CLK,
   input  logic        RST,
   seg7_scan_if.slave  bus
);

   localparam int                    IDX_W    = $clog2(NUM_DIGITS);
   localparam int                    VAL_W    = 4 * NUM_DIGITS;
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [7:0]            CNT_LAST = 8'(DIGIT_TICKS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'b1}};
   localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

   seg7_state_e             state_q;
   logic [IDX_W-1:0]        idx_q;
   logic [7:0]              cnt_q;
   logic [VAL_W-1:0]        snap_val_q;
   logic [NUM_DIGITS-1:0]   snap_dp_q;
   logic                    snap_lz_q;
   logic [NUM_DIGITS-1:0]   an_q;
   logic [6:0]              seg_q;
   logic                    dp_q;
   logic                    fd_q;

   logic [VAL_W-1:0]        upper_s;
   logic [3:0]              nib_s;
   logic                    lz_blank_s;
   logic [6:0]              seg_d;
   logic [NUM_DIGITS-1:0]   an_d;

   // Select the current digit from the snapshot and decide whether it is a
   // suppressed leading zero: all nibbles from idx upward are zero, never digit 0.
   always_comb begin
      upper_s    = snap_val_q >> {idx_q, 2'b00};
      nib_s      = upper_s[3:0];
      lz_blank_s = snap_lz_q && (idx_q != {IDX_W{1'b0}}) && (upper_s == {VAL_W{1'b0}});
      an_d       = ~(AN_ONE << idx_q);
   end

   seg7_decode u_decode (
      .nib_i   (nib_s),
      .blank_i (lz_blank_s),
      .seg_o   (seg_d)
   );

   // Scan FSM with registered pin outputs; only TICK cycles advance state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         idx_q      <= {IDX_W{1'b0}};
         cnt_q      <= 8'd0;
         snap_val_q <= {VAL_W{1'b0}};
         snap_dp_q  <= {NUM_DIGITS{1'b0}};
         snap_lz_q  <= 1'b0;
         an_q       <= AN_OFF;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
         fd_q       <= 1'b0;
      end else begin
         fd_q <= 1'b0;
         if (bus.TICK) begin
            case (state_q)
               ST_IDLE: begin
                  state_q    <= ST_BLANK;
                  idx_q      <= {IDX_W{1'b0}};
                  snap_val_q <= bus.VALUE;
                  snap_dp_q  <= bus.DP_IN;
                  snap_lz_q  <= bus.LZ_SUPPRESS;
               end
               ST_BLANK: begin
                  state_q <= ST_DRIVE;
                  cnt_q   <= 8'd0;
                  an_q    <= an_d;
                  seg_q   <= seg_d;
                  dp_q    <= ~snap_dp_q[idx_q];
               end
               ST_DRIVE: begin
                  if (cnt_q != CNT_LAST) begin
                     cnt_q <= cnt_q + 8'd1;
                  end else begin
                     state_q <= ST_BLANK;
                     an_q    <= AN_OFF;
                     seg_q   <= SEG_BLANK;
                     dp_q    <= 1'b1;
                     if (idx_q == IDX_LAST) begin
                        idx_q      <= {IDX_W{1'b0}};
                        snap_val_q <= bus.VALUE;
                        snap_dp_q  <= bus.DP_IN;
                        snap_lz_q  <= bus.LZ_SUPPRESS;
                        fd_q       <= 1'b1;
                     end else begin
                        idx_q <= idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  an_q    <= AN_OFF;
                  seg_q   <= SEG_BLANK;
                  dp_q    <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.AN         = an_q;
   assign bus.SEG        = seg_q;
   assign bus.DP         = dp_q;
   assign bus.FRAME_DONE = fd_q;

endmodule
